// File: rtl/dpi_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dpi_stream_sequencer
// Purpose  : Front-end of a DPI regex lane. It maps each 32-bit flow key to a
//            6-bit stream ID through a 64-entry register CAM. It then drives the
//            matcher wrappers through three phases: state load, character
//            stream, and end-of-packet commit.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   EOP_GAP        idle cycles between the last char_in_vld and eop (1..7)
// Ports
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   pkt_vld/sop/eop/data/key   byte-wide packet input, pkt_rdy handshake
//   load_state, new_stream_id, stream_id, char_in, char_in_vld, eop, enable
//                  matcher bundle; every output is registered
//   flows_active   occupied CAM entries (0..64)
//   pkt_count      completed packets, wraps
// Build option
//   DPI_SEQ_EVICT_EN  when defined, a miss on a full table overwrites a
//                     round-robin victim. When undefined, the packet is
//                     passed through with enable=0.
// ============================================================================
module dpi_stream_sequencer #(
    parameter int EOP_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_vld,
    input  logic        pkt_sop,
    input  logic        pkt_eop,
    input  logic [7:0]  pkt_data,
    input  logic [31:0] pkt_key,
    output logic        pkt_rdy,
    output logic        load_state,
    output logic        new_stream_id,
    output logic [5:0]  stream_id,
    output logic [7:0]  char_in,
    output logic        char_in_vld,
    output logic        eop,
    output logic        enable,
    output logic [6:0]  flows_active,
    output logic [15:0] pkt_count
);

    localparam int c_NUM_ENTRIES = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_LOAD   = 3'd2,
        S_GAP    = 3'd3,
        S_STREAM = 3'd4,
        S_DRAIN  = 3'd5,
        S_COMMIT = 3'd6
    } state_t;

    state_t r_state, w_state_nxt;

    // Packet context latched from the SOP beat
    logic [31:0] r_key;
    logic [7:0]  r_first_byte;
    logic        r_last;
    logic        w_latch;

    // CAM storage
    logic [c_NUM_ENTRIES-1:0] r_cam_vld;
    logic [31:0]              r_cam_key [c_NUM_ENTRIES];
    logic [c_NUM_ENTRIES-1:0] w_hit_vec;
    logic                     w_hit, w_free_found;
    logic [5:0]               w_hit_idx, w_free_idx;
    logic                     w_cam_we;
    logic [5:0]               w_cam_widx;

    // Registered outputs and their next values
    logic        r_pkt_rdy, w_pkt_rdy_nxt;
    logic        r_load_state, w_load_nxt;
    logic        r_new_stream_id, w_new_nxt;
    logic [5:0]  r_stream_id, w_sid_nxt;
    logic [7:0]  r_char_in, w_char_nxt;
    logic        r_char_in_vld, w_char_vld_nxt;
    logic        r_eop, w_eop_nxt;
    logic        r_enable, w_en_nxt;
    logic [6:0]  r_flows_active;
    logic        w_flows_inc;
    logic [15:0] r_pkt_count;
    logic        w_pkt_inc;
    logic [2:0]  r_gap_cnt, w_gap_cnt_nxt;

    logic        w_accept;
    assign w_accept = pkt_vld & r_pkt_rdy;

`ifdef DPI_SEQ_EVICT_EN
    logic [5:0] r_victim;
    logic       w_victim_adv;
`endif

    // Parallel compare of every valid entry against the latched key
    for (genvar g = 0; g < c_NUM_ENTRIES; g++) begin : g_cam_cmp
        assign w_hit_vec[g] = r_cam_vld[g] && (r_cam_key[g] == r_key);
    end

    // Lowest index wins for both the hit and the free-slot search
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = c_NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = 6'(i);
            end
            if (!r_cam_vld[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = 6'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pkt_rdy_nxt  = 1'b0;
        w_load_nxt     = 1'b0;
        w_eop_nxt      = 1'b0;
        w_char_vld_nxt = 1'b0;
        w_char_nxt     = r_char_in;
        w_sid_nxt      = r_stream_id;
        w_new_nxt      = r_new_stream_id;
        w_en_nxt       = r_enable;
        w_cam_we       = 1'b0;
        w_cam_widx     = w_free_idx;
        w_flows_inc    = 1'b0;
        w_pkt_inc      = 1'b0;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_latch        = 1'b0;
`ifdef DPI_SEQ_EVICT_EN
        w_victim_adv   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_pkt_rdy_nxt = 1'b1;
                // Non-SOP beats in IDLE are accepted and discarded
                if (w_accept && pkt_sop) begin
                    w_latch       = 1'b1;
                    w_state_nxt   = S_LOOKUP;
                    w_pkt_rdy_nxt = 1'b0;
                end
            end
            S_LOOKUP: begin
                w_state_nxt = S_LOAD;
                w_load_nxt  = 1'b1;
                if (w_hit) begin
                    w_sid_nxt = w_hit_idx;
                    w_new_nxt = 1'b0;
                    w_en_nxt  = 1'b1;
                end else if (w_free_found) begin
                    w_sid_nxt   = w_free_idx;
                    w_new_nxt   = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_cam_we    = 1'b1;
                    w_cam_widx  = w_free_idx;
                    w_flows_inc = 1'b1;
                end else begin
`ifdef DPI_SEQ_EVICT_EN
                    w_sid_nxt    = r_victim;
                    w_new_nxt    = 1'b1;
                    w_en_nxt     = 1'b1;
                    w_cam_we     = 1'b1;
                    w_cam_widx   = r_victim;
                    w_victim_adv = 1'b1;
`else
                    // Matchers still run, but they discard the state
                    w_sid_nxt = '0;
                    w_new_nxt = 1'b1;
                    w_en_nxt  = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                w_state_nxt    = S_STREAM;
                w_char_nxt     = r_first_byte;
                w_char_vld_nxt = 1'b1;
                w_pkt_rdy_nxt  = !r_last;
            end
            S_STREAM: begin
                if (r_last) begin
                    w_state_nxt   = S_DRAIN;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_pkt_rdy_nxt = 1'b1;
                    if (w_accept) begin
                        if (pkt_sop) begin
                            // A stray SOP ends the packet and its byte is dropped
                            w_state_nxt   = S_DRAIN;
                            w_pkt_rdy_nxt = 1'b0;
                            w_gap_cnt_nxt = '0;
                        end else begin
                            w_char_nxt     = pkt_data;
                            w_char_vld_nxt = 1'b1;
                            if (pkt_eop) begin
                                w_state_nxt   = S_DRAIN;
                                w_pkt_rdy_nxt = 1'b0;
                                w_gap_cnt_nxt = '0;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                // The gap counts only once the final character has left
                // char_in, so both entry paths give the same eop timing.
                if (!r_char_in_vld) begin
                    if (r_gap_cnt == 3'(EOP_GAP - 1)) begin
                        w_state_nxt = S_COMMIT;
                        w_eop_nxt   = 1'b1;
                        w_pkt_inc   = 1'b1;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 3'd1;
                    end
                end
            end
            S_COMMIT: begin
                w_state_nxt   = S_IDLE;
                w_pkt_rdy_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_pkt_rdy       <= 1'b0;
            r_load_state    <= 1'b0;
            r_new_stream_id <= 1'b0;
            r_stream_id     <= '0;
            r_char_in       <= '0;
            r_char_in_vld   <= 1'b0;
            r_eop           <= 1'b0;
            r_enable        <= 1'b0;
            r_flows_active  <= '0;
            r_pkt_count     <= '0;
            r_gap_cnt       <= '0;
            r_key           <= '0;
            r_first_byte    <= '0;
            r_last          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pkt_rdy       <= w_pkt_rdy_nxt;
            r_load_state    <= w_load_nxt;
            r_new_stream_id <= w_new_nxt;
            r_stream_id     <= w_sid_nxt;
            r_char_in       <= w_char_nxt;
            r_char_in_vld   <= w_char_vld_nxt;
            r_eop           <= w_eop_nxt;
            r_enable        <= w_en_nxt;
            r_flows_active  <= r_flows_active + {6'd0, w_flows_inc};
            r_pkt_count     <= r_pkt_count + {15'd0, w_pkt_inc};
            r_gap_cnt       <= w_gap_cnt_nxt;
            if (w_latch) begin
                r_key        <= pkt_key;
                r_first_byte <= pkt_data;
                r_last       <= pkt_eop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cam_vld <= '0;
        end else if (w_cam_we) begin
            r_cam_vld[w_cam_widx] <= 1'b1;
        end
    end

    // Key storage needs no reset; an entry is only trusted while its valid bit is set
    always_ff @(posedge clk) begin
        if (w_cam_we) begin
            r_cam_key[w_cam_widx] <= r_key;
        end
    end

`ifdef DPI_SEQ_EVICT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_victim <= '0;
        end else if (w_victim_adv) begin
            r_victim <= r_victim + 6'd1;
        end
    end
`endif

    assign pkt_rdy       = r_pkt_rdy;
    assign load_state    = r_load_state;
    assign new_stream_id = r_new_stream_id;
    assign stream_id     = r_stream_id;
    assign char_in       = r_char_in;
    assign char_in_vld   = r_char_in_vld;
    assign eop           = r_eop;
    assign enable        = r_enable;
    assign flows_active  = r_flows_active;
    assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_dpi_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpi_stream_sequencer
// Purpose  : Directed self-checking bench for dpi_stream_sequencer (EOP_GAP=2)
// Revision : 1.0  initial release
// ============================================================================
module tb_dpi_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_vld = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
    logic [7:0]  pkt_data = '0;
    logic [31:0] pkt_key = '0;
    logic        pkt_rdy, load_state, new_stream_id, char_in_vld, eop, enable;
    logic [5:0]  stream_id;
    logic [7:0]  char_in;
    logic [6:0]  flows_active;
    logic [15:0] pkt_count;

    dpi_stream_sequencer #(.EOP_GAP(2)) dut (
        .clk(clk), .rst(rst),
        .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_data(pkt_data), .pkt_key(pkt_key), .pkt_rdy(pkt_rdy),
        .load_state(load_state), .new_stream_id(new_stream_id),
        .stream_id(stream_id), .char_in(char_in), .char_in_vld(char_in_vld),
        .eop(eop), .enable(enable), .flows_active(flows_active),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Event recorder sampled on the falling edge
    logic [7:0] mon_chars[$];
    int         mon_ccyc[$];
    int         load_cyc = -1, eop_cyc = -1, eop_cnt = 0, sid_unstable = 0;
    logic [5:0] load_sid;
    logic       load_new, load_en, in_pkt = 1'b0;

    always @(negedge clk) begin
        if (char_in_vld) begin
            mon_chars.push_back(char_in);
            mon_ccyc.push_back(cyc);
        end
        if (load_state) begin
            load_cyc = cyc; load_sid = stream_id; load_new = new_stream_id;
            load_en = enable; in_pkt = 1'b1;
        end else if (in_pkt && (stream_id !== load_sid || enable !== load_en ||
                                new_stream_id !== load_new)) begin
            sid_unstable++;
        end
        if (eop) begin
            eop_cnt++; eop_cyc = cyc; in_pkt = 1'b0;
        end
        if (rst) in_pkt = 1'b0;
    end

    task automatic clear_mon();
        mon_chars.delete(); mon_ccyc.delete();
        load_cyc = -1; eop_cyc = -1; sid_unstable = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends len bytes base, base+1, ...; pkt_vld is held low for gap_len
    // cycles just before byte index gap_at. t_sop is the cycle the SOP is accepted.
    task automatic send_pkt(input logic [31:0] key, input int len, input logic [7:0] base,
                            input int gap_at, input int gap_len, output int t_sop);
        int i = 0, idle = 0, guard = 0;
        t_sop = -1;
        while (i < len && guard < 200) begin
            if (i == gap_at && idle < gap_len) begin
                pkt_vld = 1'b0; idle++;
            end else begin
                pkt_vld = 1'b1; pkt_sop = (i == 0); pkt_eop = (i == len - 1);
                pkt_data = base + 8'(i); pkt_key = key;
            end
            @(negedge clk);
            if (pkt_vld && pkt_rdy) begin
                if (i == 0) t_sop = cyc;
                i++;
            end
            guard++;
            @(posedge clk); #1;
        end
        pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
        n_tests++;
        if (i != len) begin
            n_fail++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", i, len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        @(negedge clk);
        n_tests++;
        if ({pkt_rdy, load_state, new_stream_id, stream_id, char_in_vld, eop, enable,
             flows_active, pkt_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b sid=%0d flows=%0d cnt=%0d, required all 0",
                     pkt_rdy, stream_id, flows_active, pkt_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(2);
        @(negedge clk);
        n_tests++;
        if (pkt_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy_idle: got %0b, required 1", pkt_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_first_packet();
        int t;
        logic ok;
        clear_mon();
        send_pkt(32'hA5A5_0001, 4, 8'h10, -1, 0, t);
        wait_cycles(12);
        n_tests++;
        if (load_cyc !== t + 2 || load_sid !== 6'd0 || load_new !== 1'b1 || load_en !== 1'b1) begin
            n_fail++;
            $display("FAIL first_load: got cyc=%0d sid=%0d new=%0b en=%0b, required cyc=%0d sid=0 new=1 en=1",
                     load_cyc, load_sid, load_new, load_en, t + 2);
        end
        ok = (mon_chars.size() == 4);
        for (int k = 0; k < 4; k++)
            if (k < mon_chars.size() && (mon_chars[k] !== 8'h10 + 8'(k) || mon_ccyc[k] != t + 4 + k))
                ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL first_chars: got %0d chars first_cyc=%0d, required 4 chars 10..13 at %0d..%0d",
                     mon_chars.size(), (mon_ccyc.size() > 0) ? mon_ccyc[0] : -1, t + 4, t + 7);
        end
        n_tests++;
        if (eop_cyc !== t + 10 || eop_cnt !== 1) begin
            n_fail++;
            $display("FAIL first_eop: got cyc=%0d count=%0d, required cyc=%0d count=1", eop_cyc, eop_cnt, t + 10);
        end
        n_tests++;
        if (flows_active !== 7'd1 || pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL first_counters: got flows=%0d pkts=%0d, required 1 1", flows_active, pkt_count);
        end
    endtask

    task automatic test_lookup_hit_and_new();
        int t;
        clear_mon();
        send_pkt(32'hA5A5_0001, 2, 8'h20, -1, 0, t);
        wait_cycles(10);
        n_tests++;
        if (load_sid !== 6'd0 || load_new !== 1'b0 || load_en !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_same_key: got sid=%0d new=%0b en=%0b, required 0 0 1", load_sid, load_new, load_en);
        end
        clear_mon();
        send_pkt(32'h0000_0002, 2, 8'h28, -1, 0, t);
        wait_cycles(10);
        n_tests++;
        if (load_sid !== 6'd1 || load_new !== 1'b1 || flows_active !== 7'd2 || pkt_count !== 16'd3) begin
            n_fail++;
            $display("FAIL new_key: got sid=%0d new=%0b flows=%0d pkts=%0d, required 1 1 2 3",
                     load_sid, load_new, flows_active, pkt_count);
        end
    endtask

    task automatic test_single_byte();
        int t, rdy_bad = 0;
        clear_mon();
        send_pkt(32'h0000_0002, 1, 8'h55, -1, 0, t);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (pkt_rdy !== 1'b0) rdy_bad++;
        end
        @(negedge clk);
        n_tests++;
        if (rdy_bad != 0 || pkt_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rdy: got %0d high cycles in t+1..t+7, rdy at t+8=%0b, required 0 and 1",
                     rdy_bad, pkt_rdy);
        end
        @(posedge clk); #1;
        wait_cycles(3);
        n_tests++;
        if (mon_chars.size() != 1 || mon_chars[0] !== 8'h55 || mon_ccyc[0] != t + 4) begin
            n_fail++;
            $display("FAIL single_char: got %0d chars, required one 0x55 at cycle %0d", mon_chars.size(), t + 4);
        end
        n_tests++;
        if (eop_cyc !== t + 7 || load_sid !== 6'd1 || load_new !== 1'b0 || sid_unstable != 0) begin
            n_fail++;
            $display("FAIL single_eop: got eop=%0d sid=%0d new=%0b unstable=%0d, required eop=%0d sid=1 new=0 unstable=0",
                     eop_cyc, load_sid, load_new, sid_unstable, t + 7);
        end
    endtask

    task automatic test_vld_gap();
        int t;
        logic ok;
        int exp_cyc[5];
        clear_mon();
        send_pkt(32'hA5A5_0001, 5, 8'h30, 2, 3, t);
        wait_cycles(10);
        exp_cyc = '{t + 4, t + 5, t + 9, t + 10, t + 11};
        ok = (mon_chars.size() == 5);
        for (int k = 0; k < 5; k++)
            if (k < mon_chars.size() && (mon_chars[k] !== 8'h30 + 8'(k) || mon_ccyc[k] != exp_cyc[k]))
                ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL gap_chars: got %0d chars, required 5 in order 30..34 with no valid during the gap",
                     mon_chars.size());
        end
        n_tests++;
        if (eop_cyc !== t + 14 || load_sid !== 6'd0 || sid_unstable != 0) begin
            n_fail++;
            $display("FAIL gap_eop_sid: got eop=%0d sid=%0d unstable=%0d, required eop=%0d sid=0 unstable=0",
                     eop_cyc, load_sid, sid_unstable, t + 14);
        end
    endtask

    task automatic test_table_full();
        int t;
        for (int k = 0; k < 62; k++) begin
            clear_mon();
            send_pkt(32'h1000_0000 + 32'(k), 1, 8'(k), -1, 0, t);
            wait_cycles(8);
        end
        n_tests++;
        if (flows_active !== 7'd64 || load_sid !== 6'd63 || load_new !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_64: got flows=%0d last_sid=%0d new=%0b, required 64 63 1",
                     flows_active, load_sid, load_new);
        end
        clear_mon();
        send_pkt(32'hDEAD_BEEF, 1, 8'hEE, -1, 0, t);
        wait_cycles(8);
`ifdef DPI_SEQ_EVICT_EN
        n_tests++;
        if (load_sid !== 6'd0 || load_new !== 1'b1 || load_en !== 1'b1 || flows_active !== 7'd64) begin
            n_fail++;
            $display("FAIL full_evict: got sid=%0d new=%0b en=%0b flows=%0d, required 0 1 1 64",
                     load_sid, load_new, load_en, flows_active);
        end
`else
        n_tests++;
        if (load_sid !== 6'd0 || load_new !== 1'b1 || load_en !== 1'b0 || flows_active !== 7'd64) begin
            n_fail++;
            $display("FAIL full_bypass: got sid=%0d new=%0b en=%0b flows=%0d, required 0 1 0 64",
                     load_sid, load_new, load_en, flows_active);
        end
`endif
        n_tests++;
        if (mon_chars.size() != 1 || eop_cyc !== t + 7) begin
            n_fail++;
            $display("FAIL full_sequence: got chars=%0d eop=%0d, required 1 and %0d", mon_chars.size(), eop_cyc, t + 7);
        end
        clear_mon();
        send_pkt(32'hA5A5_0001, 1, 8'h01, -1, 0, t);
        wait_cycles(8);
`ifdef DPI_SEQ_EVICT_EN
        n_tests++;
        if (load_sid !== 6'd1 || load_new !== 1'b1 || load_en !== 1'b1) begin
            n_fail++;
            $display("FAIL evict_next_victim: got sid=%0d new=%0b en=%0b, required 1 1 1", load_sid, load_new, load_en);
        end
`else
        n_tests++;
        if (load_sid !== 6'd0 || load_new !== 1'b0 || load_en !== 1'b1) begin
            n_fail++;
            $display("FAIL full_first_key_hit: got sid=%0d new=%0b en=%0b, required 0 0 1", load_sid, load_new, load_en);
        end
`endif
        n_tests++;
        if (pkt_count !== 16'd69) begin
            n_fail++;
            $display("FAIL full_pkt_count: got %0d, required 69", pkt_count);
        end
    endtask

    task automatic test_reset_mid_stream();
        int t, guard = 0, eops_before;
        logic acc = 1'b0;
        clear_mon();
        eops_before = eop_cnt;
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_data = 8'hE0; pkt_key = 32'h0000_0077;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = pkt_rdy;
            guard++;
            @(posedge clk); #1;
        end
        pkt_sop = 1'b0; pkt_data = 8'hE1;
        wait_cycles(4);
        rst = 1'b1; pkt_vld = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(12);
        n_tests++;
        if (!acc || eop_cnt != eops_before || flows_active !== 7'd0 || pkt_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_state: got acc=%0b eops=%0d flows=%0d pkts=%0d, required 1 %0d 0 0",
                     acc, eop_cnt, flows_active, pkt_count, eops_before);
        end
        clear_mon();
        send_pkt(32'hA5A5_0001, 2, 8'h40, -1, 0, t);
        wait_cycles(10);
        n_tests++;
        if (load_sid !== 6'd0 || load_new !== 1'b1 || load_en !== 1'b1 || flows_active !== 7'd1) begin
            n_fail++;
            $display("FAIL midrst_new_flow: got sid=%0d new=%0b en=%0b flows=%0d, required 0 1 1 1",
                     load_sid, load_new, load_en, flows_active);
        end
    endtask

    initial begin
        test_reset();
        test_first_packet();
        test_lookup_hit_and_new();
        test_single_byte();
        test_vld_gap();
        test_table_full();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpi_stream_sequencer.md
# dpi_stream_sequencer

Upstream front-end of each DPI regex lane. It accepts byte-wide packets tagged with a 32-bit flow key and maps each flow key to a 6-bit stream ID through a 64-entry register CAM. It then drives the per-lane matcher wrappers through a fixed sequence: state load, character stream, then end-of-packet commit. Its output bundle (`load_state`, `new_stream_id`, `stream_id`, `char_in`, `char_in_vld`, `eop`, `enable`) connects directly to every cancid regex wrapper in the lane.

## Interface
- `EOP_GAP`, default 2: idle cycles between the last `char_in_vld` and the `eop` pulse; covers matcher accept latency; legal range 1..7.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pkt_vld`  in  1  input beat valid.
- `pkt_sop`  in  1  first beat of packet; `pkt_key` is valid on this beat.
- `pkt_eop`  in  1  last beat of packet.
- `pkt_data`  in  8  payload byte; every beat carries exactly one byte.
- `pkt_key`  in  32  flow key; sampled only on an accepted SOP beat.
- `pkt_rdy`  out  1  beat accepted when `pkt_vld & pkt_rdy`.
- `load_state`  out  1  one-cycle pulse; matchers restore or clear stream state.
- `new_stream_id`  out  1  stream ID freshly allocated; matchers zero their state.
- `stream_id`  out  6  stream ID, held from `load_state` through `eop`.
- `char_in`, `char_in_vld`  out  8, 1  payload byte stream.
- `eop`  out  1  one-cycle commit pulse.
- `enable`  out  1  0 means the packet is passed through without inspection and state is not saved; held with `stream_id`.
- `flows_active`  out  7  number of occupied CAM entries, 0..64.
- `pkt_count`  out  16  number of completed packets; wraps at 65535 -> 0.

## Operation
- CAM: 64 entries, each holding {valid, key[31:0]}. Compare is fully parallel against the latched key. A hit returns the lowest matching index.
- FSM states: IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, COMMIT.
- IDLE: `pkt_rdy`=1. An accepted beat with `pkt_sop` latches the key, the byte, and `pkt_eop` (as the last flag), then moves to LOOKUP. An accepted beat without `pkt_sop` is dropped and the FSM stays in IDLE.
- LOOKUP, hit: `stream_id`=index, `new_stream_id`=0, `enable`=1.
- LOOKUP, miss with a free entry: allocate the lowest free index, write the key, set `new_stream_id`=1, `enable`=1, increment `flows_active`.
- LOOKUP, miss with the table full: behaviour is set by configuration.
- LOAD: `load_state`=1 for exactly this cycle.
- GAP: one cycle so that the wrapper's registered state load lands before the first character.
- STREAM: the first cycle emits the latched SOP byte. If the latched last flag is set, go to DRAIN. Otherwise `pkt_rdy`=1, and each accepted beat appears on `char_in`/`char_in_vld` one cycle later. An accepted beat with `pkt_eop` moves the FSM to DRAIN after its byte is emitted. A beat with `pkt_sop` in STREAM is a protocol error: its byte is dropped and it is treated as `pkt_eop`.
- DRAIN: `pkt_rdy`=0 and a counter runs `EOP_GAP` cycles.
- COMMIT: `eop`=1 for one cycle, `pkt_count` increments, then return to IDLE.
- `pkt_rdy`=0 in LOOKUP, LOAD, GAP, DRAIN and COMMIT.

## Timing
- All outputs are registered.
- Reset values: `pkt_rdy`=0 for the reset cycle, then 1 in IDLE. All other outputs are 0. CAM valid bits are cleared; key contents are don't-care.
- SOP beat accepted at cycle t: LOOKUP at t+1, `load_state` at t+2, first `char_in_vld` at t+4.
- Last char at cycle c: `eop` at c+`EOP_GAP`+1.
- Minimum SOP-to-SOP spacing for a single-byte packet: 6+`EOP_GAP` cycles.
- `stream_id`, `new_stream_id` and `enable` are stable from `load_state` through `eop`, and change only at LOOKUP.
- `rst` asserted mid-packet: the FSM returns to IDLE, no `eop` is issued, and the CAM is cleared.
- `pkt_count` and `flows_active` update in the same cycle as `eop` and allocation respectively.

## Configuration
- `DPI_SEQ_EVICT_EN` defined: on a miss with a full table, a 6-bit round-robin victim pointer (reset 0) selects the entry to overwrite. The key is replaced, `new_stream_id`=1, `enable`=1, and the pointer advances (63 -> 0). `flows_active` stays at 64.
- `DPI_SEQ_EVICT_EN` undefined: on a miss with a full table, `stream_id`=0, `new_stream_id`=1 and `enable`=0. The full sequence still runs, including `load_state`, chars and `eop`, so matchers run but discard the state. The CAM is unchanged.

## Test plan
- Key 0xA5A5_0001, 4-byte packet after reset: `load_state` at t+2 with `stream_id`=0 and `new_stream_id`=1; chars at t+4..t+7; `eop` at t+10 (EOP_GAP=2); `flows_active`=1; `pkt_count`=1.
- Same key again: `stream_id`=0, `new_stream_id`=0. A new key 0x0000_0002 then gets `stream_id`=1.
- Single-byte packet (SOP and EOP on one beat): exactly one `char_in_vld`, `eop` 3 cycles later, `pkt_rdy` low from t+1 until IDLE.
- Drop `pkt_vld` for 3 cycles mid-packet: no `char_in_vld` during the gap, byte order preserved, `stream_id` stable.
- Fill 64 keys, then send a 65th. With `DPI_SEQ_EVICT_EN`: `stream_id`=0, `new_stream_id`=1, next victim 1. Without it: `enable`=0, `stream_id`=0, and a re-sent first key still hits ID 0.
- Assert `rst` during STREAM: no `eop` is issued, `flows_active`=0, and the next SOP is treated as new with `stream_id`=0.
